// File: rtl/result_encoder.sv
// -----------------------------------------------------------------------------
// result_encoder
//
// Serialises one calculator result into an ASCII frame for a byte-wide UART
// transmitter using a valid/ready handshake.
//
// Frame layout:
//   'O' ' ' <type> [8 lowercase hex digits, MSB first] [CR LF]
//   <type> is 'W' (unsigned), 'S' (signed), '?' (other dtype) or 'E' (error).
//   On error the hex digits are left out.
//
// Build option:
//   RESULT_ENC_CRLF_EN  defined   -> the frame ends with CR LF (13 / 5 bytes)
//                       undefined -> no terminator             (11 / 3 bytes)
//
// Ports:
//   clk       in   1   system clock, rising edge
//   n_rst     in   1   asynchronous active-low reset
//   start     in   1   request one frame; taken only while busy=0
//   result    in  32   value to print, captured on an accepted start
//   dtype     in   4   4'h1 unsigned, 4'h2 signed, captured with result
//   err       in   1   calculator error flag, captured with result
//   tx_data   out  8   ASCII byte offered to the transmitter
//   tx_valid  out  1   tx_data holds a byte; transfer when tx_ready=1
//   tx_ready  in   1   transmitter accepts the byte on this edge
//   busy      out  1   frame in progress (start is ignored)
//   done      out  1   one-cycle pulse after the final byte has transferred
// -----------------------------------------------------------------------------
module result_encoder (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        start,
  input  logic [31:0] result,
  input  logic [3:0]  dtype,
  input  logic        err,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy,
  output logic        done
);

`ifdef RESULT_ENC_CRLF_EN
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HEAD  = 3'd1,
    SPACE = 3'd2,
    TYPE  = 3'd3,
    DIGIT = 3'd4,
    CR    = 3'd5,
    LF    = 3'd6,
    DONE  = 3'd7
  } state_t;

  // State that follows the type/digit section of the frame.
  localparam state_t TERM_STATE = CR;
`else
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HEAD  = 3'd1,
    SPACE = 3'd2,
    TYPE  = 3'd3,
    DIGIT = 3'd4,
    DONE  = 3'd7
  } state_t;

  localparam state_t TERM_STATE = DONE;
`endif

  localparam logic [7:0] CH_O     = 8'h4F;
  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam logic [7:0] CH_W     = 8'h57;
  localparam logic [7:0] CH_S     = 8'h53;
  localparam logic [7:0] CH_QUERY = 8'h3F;
  localparam logic [7:0] CH_E     = 8'h45;
`ifdef RESULT_ENC_CRLF_EN
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_LF    = 8'h0A;
`endif

  state_t      r_state;
  state_t      w_next_state;
  logic [2:0]  r_cnt;
  logic [31:0] r_result;
  logic [3:0]  r_dtype;
  logic        r_err;

  logic        w_accept;
  logic        w_xfer;
  logic [3:0]  w_nibble;
  logic [7:0]  w_hex;
  logic [7:0]  w_type_char;

  assign w_accept = start && (r_state == IDLE);
  assign w_xfer   = tx_valid && tx_ready;

  // Counter value n selects result bits [4n+3:4n], so 7 is the MSB nibble.
  assign w_nibble = r_result[{r_cnt, 2'b00} +: 4];
  // 'a' - 10 = 0x57, which maps nibble 10..15 onto 'a'..'f'.
  assign w_hex    = (w_nibble < 4'd10) ? (8'h30 + {4'h0, w_nibble})
                                       : (8'h57 + {4'h0, w_nibble});

  always_comb begin
    w_type_char = CH_QUERY;
    if (r_err) begin
      w_type_char = CH_E;
    end else if (r_dtype == 4'h1) begin
      w_type_char = CH_W;
    end else if (r_dtype == 4'h2) begin
      w_type_char = CH_S;
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the pre-edge values, independent of statement order.
  // NOTE: the captured operands are reset along with the control state; they
  // are a handful of flops, not a memory, so clearing them costs nothing and
  // keeps post-reset values deterministic.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state  <= IDLE;
      r_cnt    <= 3'd0;
      r_result <= 32'h0;
      r_dtype  <= 4'h0;
      r_err    <= 1'b0;
    end else begin
      r_state <= w_next_state;

      // Operands are frozen for the whole frame; later input changes are
      // ignored until the block is back in IDLE.
      if (w_accept) begin
        r_result <= result;
        r_dtype  <= dtype;
        r_err    <= err;
      end

      // Arm the digit counter as TYPE hands over to DIGIT, then count down
      // one step per transferred digit; it rests at 0 after the last one.
      if ((r_state == TYPE) && w_xfer) begin
        r_cnt <= 3'd7;
      end else if ((r_state == DIGIT) && w_xfer && (r_cnt != 3'd0)) begin
        r_cnt <= r_cnt - 3'd1;
      end
    end
  end

  // NOTE: every signal driven here gets a default before the case statement,
  // so no path leaves a value unassigned and no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    tx_data      = 8'h00;
    tx_valid     = 1'b0;
    busy         = 1'b1;
    done         = 1'b0;

    unique case (r_state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          w_next_state = HEAD;
        end
      end

      HEAD: begin
        tx_valid = 1'b1;
        tx_data  = CH_O;
        if (w_xfer) begin
          w_next_state = SPACE;
        end
      end

      SPACE: begin
        tx_valid = 1'b1;
        tx_data  = CH_SPACE;
        if (w_xfer) begin
          w_next_state = TYPE;
        end
      end

      TYPE: begin
        tx_valid = 1'b1;
        tx_data  = w_type_char;
        if (w_xfer) begin
          w_next_state = r_err ? TERM_STATE : DIGIT;
        end
      end

      DIGIT: begin
        tx_valid = 1'b1;
        tx_data  = w_hex;
        if (w_xfer && (r_cnt == 3'd0)) begin
          w_next_state = TERM_STATE;
        end
      end

`ifdef RESULT_ENC_CRLF_EN
      CR: begin
        tx_valid = 1'b1;
        tx_data  = CH_CR;
        if (w_xfer) begin
          w_next_state = LF;
        end
      end

      LF: begin
        tx_valid = 1'b1;
        tx_data  = CH_LF;
        if (w_xfer) begin
          w_next_state = DONE;
        end
      end
`endif

      DONE: begin
        done         = 1'b1;
        w_next_state = IDLE;
      end

      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

endmodule

// File: doc/result_encoder.md
RESULT_ENCODER -- requirements
Module: result_encoder

Interface
REQ-001 SHALL provide port: clk  input  1  system clock; all logic on rising edge.
REQ-002 SHALL provide port: n_rst  input  1  reset, asynchronous, active-low.
REQ-003 SHALL provide port: start  input  1  one-cycle request to transmit one result frame.
REQ-004 SHALL provide port: result  input  32  calculator result; sampled when start is accepted.
REQ-005 SHALL provide port: dtype  input  4  data type, 4'h1 unsigned, 4'h2 signed; sampled with result.
REQ-006 SHALL provide port: err  input  1  calculator error flag, e.g. divide by zero; sampled with result.
REQ-007 SHALL provide port: tx_data  output  8  ASCII byte to UART transmitter.
REQ-008 SHALL provide port: tx_valid  output  1  tx_data holds a byte to transfer.
REQ-009 SHALL provide port: tx_ready  input  1  UART transmitter accepts a byte.
REQ-010 SHALL provide port: busy  output  1  frame in progress; start ignored.
REQ-011 SHALL provide port: done  output  1  one-cycle pulse after the final byte of a frame transfers.

Function
REQ-012 Byte transfer SHALL occur on each rising edge where tx_valid and tx_ready are both 1.
REQ-013 tx_data SHALL remain constant while tx_valid=1 and tx_ready=0; tx_valid SHALL not drop before the transfer.
REQ-014 start SHALL be accepted only when busy=0. It SHALL capture result, dtype and err, and set busy=1 on the next edge. start while busy=1 SHALL be ignored.
REQ-015 tx_valid SHALL rise in the cycle after the start is accepted. The first byte SHALL be 0x4F 'O'.
REQ-016 States SHALL be IDLE, HEAD, SPACE, TYPE, DIGIT, CR, LF and DONE. Each non-IDLE/DONE state SHALL advance only on a transfer.
REQ-017 HEAD SHALL send 0x4F, then SPACE. SPACE SHALL send 0x20, then TYPE.
REQ-018 If err=0, TYPE SHALL send 0x57 for dtype 4'h1, 0x53 for dtype 4'h2, and 0x3F for any other dtype, then go to DIGIT.
REQ-019 If err=1, TYPE SHALL send 0x45 'E' and skip DIGIT, going to CR, or to DONE when REQ-031 is disabled.
REQ-020 DIGIT SHALL send 8 hex digits of the captured result, MSB nibble first, using a 3-bit counter from 7 down to 0. It SHALL exit after the digit with counter 0 transfers.
REQ-021 Nibble encoding SHALL be 0-9 -> 0x30-0x39 and a-f -> 0x61-0x66 (lowercase).
REQ-022 CR SHALL send 0x0D, then LF. LF SHALL send 0x0A, then DONE.
REQ-023 DONE SHALL last exactly one cycle with tx_valid=0, done=1 and busy=1, then go to IDLE, where busy=0.
REQ-024 Back-to-back operation: start asserted in the first IDLE cycle after DONE SHALL be accepted, giving a minimum gap of 2 cycles between frames.
REQ-025 Captured result, dtype and err SHALL hold for the whole frame, independent of input changes.

Reset
REQ-026 n_rst=0 SHALL immediately force state IDLE, tx_valid=0, tx_data=8'h00, busy=0, done=0, digit counter=0 and captured registers=0.
REQ-027 Reset mid-frame SHALL abort the frame with no further bytes and no done pulse. After release, the block SHALL wait for a new start.

Configuration
REQ-028 Macro RESULT_ENC_CRLF_EN SHALL select the frame terminator.
REQ-029 With RESULT_ENC_CRLF_EN defined, the CR and LF states SHALL exist. A frame SHALL be 13 bytes for err=0 and 5 bytes for err=1.
REQ-030 Without RESULT_ENC_CRLF_EN, the CR and LF states SHALL be compiled out and DIGIT/TYPE SHALL go directly to DONE. A frame SHALL be 11 bytes for err=0 and 3 bytes for err=1.
REQ-031 "CR/LF enabled" in REQ-019 and REQ-022 SHALL mean RESULT_ENC_CRLF_EN is defined.

Verification
REQ-032 CRLF_EN, tx_ready=1, start with result=32'h1234abcd, dtype=1, err=0 -> bytes 4F 20 57 31 32 33 34 61 62 63 64 0D 0A, then done pulse one cycle after 0A, and busy low one cycle later.
REQ-033 CRLF_EN, start with result=32'hdeadbeef, dtype=2, err=1 -> bytes 4F 20 45 0D 0A; no digits.
REQ-034 tx_ready toggled 1/0 every cycle, result=32'h0000000f, dtype=4'h7 -> 4F 20 3F 30x7 66 0D 0A; tx_data stable during every stall.
REQ-035 Second start pulse during a busy frame with result=32'h11111111 -> ignored; first frame completes unchanged.
REQ-036 n_rst pulsed after the 5th byte transfers -> tx_valid=0 immediately; no done; a new start afterwards sends a full correct frame.
REQ-037 RESULT_ENC_CRLF_EN undefined, result=32'h00000000, dtype=1, err=0 -> 4F 20 57 followed by 30 eight times, 11 bytes total, then done.
